// File: rtl/cpu_pkg.sv
// Shared definitions for the five-stage 64-bit ARM-subset CPU.
// Holds the datapath and field widths, the ALU B-source encoding and
// the bit positions of the N/Z/V/C condition flags.
package cpu_pkg;

    localparam int DATA_W     = 64;
    localparam int INSTR_W    = 32;
    localparam int REG_ADDR_W = 5;
    localparam int ALUOP_W    = 3;
    localparam int ALUSRC_W   = 2;

    // ALU operand-B source select
    localparam logic [ALUSRC_W-1:0] ALUSRC_DB     = 2'd0;
    localparam logic [ALUSRC_W-1:0] ALUSRC_DADDR9 = 2'd1;
    localparam logic [ALUSRC_W-1:0] ALUSRC_IMM12  = 2'd2;
    localparam logic [ALUSRC_W-1:0] ALUSRC_LSR    = 2'd3;

    // Bit index of each condition flag inside the 4-bit nzvc vector
    typedef enum logic [1:0] {
        FLAG_C = 2'd0,
        FLAG_V = 2'd1,
        FLAG_Z = 2'd2,
        FLAG_N = 2'd3
    } flag_idx_e;

endpackage

// File: rtl/ex_pipe_regs_if.sv
// Bundle of every signal crossing the pipeline-state block.
// slave  : the register block (id_*/exm_*/flag inputs, ex_*/mem_*/nzvc outputs)
// master : the surrounding decode/ALU logic driving it.
interface ex_pipe_regs_if;
    import cpu_pkg::*;

    // flag register
    logic                  flag_we;
    logic [3:0]            alu_nzvc;
    logic [3:0]            nzvc;
    // ID/EX stage
    logic                  id_regwrite,  ex_regwrite;
    logic                  id_memwrite,  ex_memwrite;
    logic [ALUOP_W-1:0]    id_aluop,     ex_aluop;
    logic [ALUSRC_W-1:0]   id_alusrc,    ex_alusrc;
    logic                  id_memtoreg,  ex_memtoreg;
    logic                  id_flagwrite, ex_flagwrite;
    logic [INSTR_W-1:0]    id_instr,     ex_instr;
    logic [DATA_W-1:0]     id_imm12,     ex_imm12;
    logic [DATA_W-1:0]     id_daddr9,    ex_daddr9;
    logic [DATA_W-1:0]     id_lsr,       ex_lsr;
    logic [REG_ADDR_W-1:0] id_rd,        ex_rd;
    logic [DATA_W-1:0]     id_da,        ex_da;
    logic [DATA_W-1:0]     id_db,        ex_db;
    // EX/MEM stage
    logic [DATA_W-1:0]     exm_alures,   mem_alures;
    logic [DATA_W-1:0]     exm_db,       mem_db;
    logic [DATA_W-1:0]     exm_daddr9,   mem_daddr9;
    logic                  exm_memwrite, mem_memwrite;
    logic                  exm_memtoreg, mem_memtoreg;
    logic                  exm_flagwrite, mem_flagwrite;
    logic                  exm_regwrite, mem_regwrite;
    logic [REG_ADDR_W-1:0] exm_rd,       mem_rd;

    modport slave (
        input  flag_we, alu_nzvc,
        input  id_regwrite, id_memwrite, id_aluop, id_alusrc, id_memtoreg,
               id_flagwrite, id_instr, id_imm12, id_daddr9, id_lsr, id_rd,
               id_da, id_db,
        input  exm_alures, exm_db, exm_daddr9, exm_memwrite, exm_memtoreg,
               exm_flagwrite, exm_regwrite, exm_rd,
        output nzvc,
        output ex_regwrite, ex_memwrite, ex_aluop, ex_alusrc, ex_memtoreg,
               ex_flagwrite, ex_instr, ex_imm12, ex_daddr9, ex_lsr, ex_rd,
               ex_da, ex_db,
        output mem_alures, mem_db, mem_daddr9, mem_memwrite, mem_memtoreg,
               mem_flagwrite, mem_regwrite, mem_rd
    );

    modport master (
        output flag_we, alu_nzvc,
        output id_regwrite, id_memwrite, id_aluop, id_alusrc, id_memtoreg,
               id_flagwrite, id_instr, id_imm12, id_daddr9, id_lsr, id_rd,
               id_da, id_db,
        output exm_alures, exm_db, exm_daddr9, exm_memwrite, exm_memtoreg,
               exm_flagwrite, exm_regwrite, exm_rd,
        input  nzvc,
        input  ex_regwrite, ex_memwrite, ex_aluop, ex_alusrc, ex_memtoreg,
               ex_flagwrite, ex_instr, ex_imm12, ex_daddr9, ex_lsr, ex_rd,
               ex_da, ex_db,
        input  mem_alures, mem_db, mem_daddr9, mem_memwrite, mem_memtoreg,
               mem_flagwrite, mem_regwrite, mem_rd
    );

endinterface

// File: rtl/dff_en_w.sv
// Generic W-bit register with synchronous active-high reset and load enable.
// Ports: clk, reset (sync, clears to 0, beats en_i), en_i (load), d_i, q_o.
module dff_en_w #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // Next state: load when enabled, otherwise hold
    always_comb begin
        q_d = q_q;
        if (en_i) begin
            q_d = d_i;
        end else begin
            q_d = q_q;
        end
    end

    // State register with synchronous clear
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= {W{1'b0}};
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/ex_pipe_regs.sv
// Pipeline-state block: ID/EX register, EX/MEM register and the
// enable-gated N/Z/V/C flag register. Pure storage, one clock edge.
// Ports: clk, reset (sync active-high, clears everything),
//        bus (ex_pipe_regs_if.slave) carrying all stage fields and flags.
// Pipeline fields load every edge; bubbles come from upstream zeroing
// the control inputs, so there is no stall/flush here.
module ex_pipe_regs
    import cpu_pkg::*;
(
    input logic           clk,
    input logic           reset,
    ex_pipe_regs_if.slave bus
);

    // Condition flags: only updated when the EX-stage instruction sets flags
    dff_en_w #(.W(4)) u_nzvc (.clk(clk), .reset(reset), .en_i(bus.flag_we),
        .d_i(bus.alu_nzvc), .q_o(bus.nzvc));

    // ---------------- ID/EX ----------------
    dff_en_w #(.W(1)) u_ex_regwrite (.clk(clk), .reset(reset), .en_i(1'b1),
        .d_i(bus.id_regwrite), .q_o(bus.ex_regwrite));
    dff_en_w #(.W(1)) u_ex_memwrite (.clk(clk), .reset(reset), .en_i(1'b1),
        .d_i(bus.id_memwrite), .q_o(bus.ex_memwrite));
    dff_en_w #(.W(ALUOP_W)) u_ex_aluop (.clk(clk), .reset(reset), .en_i(1'b1),
        .d_i(bus.id_aluop), .q_o(bus.ex_aluop));
    dff_en_w #(.W(ALUSRC_W)) u_ex_alusrc (.clk(clk), .reset(reset), .en_i(1'b1),
        .d_i(bus.id_alusrc), .q_o(bus.ex_alusrc));
    dff_en_w #(.W(1)) u_ex_memtoreg (.clk(clk), .reset(reset), .en_i(1'b1),
        .d_i(bus.id_memtoreg), .q_o(bus.ex_memtoreg));
    dff_en_w #(.W(1)) u_ex_flagwrite (.clk(clk), .reset(reset), .en_i(1'b1),
        .d_i(bus.id_flagwrite), .q_o(bus.ex_flagwrite));
    dff_en_w #(.W(INSTR_W)) u_ex_instr (.clk(clk), .reset(reset), .en_i(1'b1),
        .d_i(bus.id_instr), .q_o(bus.ex_instr));
    dff_en_w #(.W(DATA_W)) u_ex_imm12 (.clk(clk), .reset(reset), .en_i(1'b1),
        .d_i(bus.id_imm12), .q_o(bus.ex_imm12));
    dff_en_w #(.W(DATA_W)) u_ex_daddr9 (.clk(clk), .reset(reset), .en_i(1'b1),
        .d_i(bus.id_daddr9), .q_o(bus.ex_daddr9));
    dff_en_w #(.W(DATA_W)) u_ex_lsr (.clk(clk), .reset(reset), .en_i(1'b1),
        .d_i(bus.id_lsr), .q_o(bus.ex_lsr));
    dff_en_w #(.W(REG_ADDR_W)) u_ex_rd (.clk(clk), .reset(reset), .en_i(1'b1),
        .d_i(bus.id_rd), .q_o(bus.ex_rd));
    dff_en_w #(.W(DATA_W)) u_ex_da (.clk(clk), .reset(reset), .en_i(1'b1),
        .d_i(bus.id_da), .q_o(bus.ex_da));
    dff_en_w #(.W(DATA_W)) u_ex_db (.clk(clk), .reset(reset), .en_i(1'b1),
        .d_i(bus.id_db), .q_o(bus.ex_db));

    // ---------------- EX/MEM ----------------
    dff_en_w #(.W(DATA_W)) u_mem_alures (.clk(clk), .reset(reset), .en_i(1'b1),
        .d_i(bus.exm_alures), .q_o(bus.mem_alures));
    dff_en_w #(.W(DATA_W)) u_mem_db (.clk(clk), .reset(reset), .en_i(1'b1),
        .d_i(bus.exm_db), .q_o(bus.mem_db));
    dff_en_w #(.W(DATA_W)) u_mem_daddr9 (.clk(clk), .reset(reset), .en_i(1'b1),
        .d_i(bus.exm_daddr9), .q_o(bus.mem_daddr9));
    dff_en_w #(.W(1)) u_mem_memwrite (.clk(clk), .reset(reset), .en_i(1'b1),
        .d_i(bus.exm_memwrite), .q_o(bus.mem_memwrite));
    dff_en_w #(.W(1)) u_mem_memtoreg (.clk(clk), .reset(reset), .en_i(1'b1),
        .d_i(bus.exm_memtoreg), .q_o(bus.mem_memtoreg));
    dff_en_w #(.W(1)) u_mem_flagwrite (.clk(clk), .reset(reset), .en_i(1'b1),
        .d_i(bus.exm_flagwrite), .q_o(bus.mem_flagwrite));
    dff_en_w #(.W(1)) u_mem_regwrite (.clk(clk), .reset(reset), .en_i(1'b1),
        .d_i(bus.exm_regwrite), .q_o(bus.mem_regwrite));
    dff_en_w #(.W(REG_ADDR_W)) u_mem_rd (.clk(clk), .reset(reset), .en_i(1'b1),
        .d_i(bus.exm_rd), .q_o(bus.mem_rd));

endmodule

// File: tb/tb_ex_pipe_regs.sv
// Self-checking bench for ex_pipe_regs. Each cycle the bench predicts the
// register contents after the coming edge, queues that prediction, and
// compares it against the DUT outputs just after the edge. Outputs are also
// compared against the previous prediction before the edge to show that
// input changes between edges do not leak through.
module tb_ex_pipe_regs;
    import cpu_pkg::*;

    typedef struct packed {
        logic [3:0]  nzvc;
        logic        regwrite, memwrite;
        logic [2:0]  aluop;
        logic [1:0]  alusrc;
        logic        memtoreg, flagwrite;
        logic [31:0] instr;
        logic [63:0] imm12, daddr9, lsr;
        logic [4:0]  rd;
        logic [63:0] da, db;
        logic [63:0] m_alures, m_db, m_daddr9;
        logic        m_memwrite, m_memtoreg, m_flagwrite, m_regwrite;
        logic [4:0]  m_rd;
    } exp_t;

    logic clk;
    logic reset;
    ex_pipe_regs_if bus ();

    int   chk_cnt;
    int   err_cnt;
    exp_t sb_q[$];
    exp_t model_q;
    bit   model_valid;
    logic [1:0] src_tbl [4];

    ex_pipe_regs dut (.clk(clk), .reset(reset), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t sample();
        exp_t s;
        s.nzvc = bus.nzvc;           s.regwrite = bus.ex_regwrite;
        s.memwrite = bus.ex_memwrite; s.aluop = bus.ex_aluop;
        s.alusrc = bus.ex_alusrc;     s.memtoreg = bus.ex_memtoreg;
        s.flagwrite = bus.ex_flagwrite; s.instr = bus.ex_instr;
        s.imm12 = bus.ex_imm12;       s.daddr9 = bus.ex_daddr9;
        s.lsr = bus.ex_lsr;           s.rd = bus.ex_rd;
        s.da = bus.ex_da;             s.db = bus.ex_db;
        s.m_alures = bus.mem_alures;  s.m_db = bus.mem_db;
        s.m_daddr9 = bus.mem_daddr9;  s.m_memwrite = bus.mem_memwrite;
        s.m_memtoreg = bus.mem_memtoreg; s.m_flagwrite = bus.mem_flagwrite;
        s.m_regwrite = bus.mem_regwrite; s.m_rd = bus.mem_rd;
        return s;
    endfunction

    // Expected contents after the next edge, built from the current inputs
    function automatic exp_t predict(input exp_t cur, input logic rst);
        exp_t n;
        n = '0;
        if (!rst) begin
            n.nzvc = bus.flag_we ? bus.alu_nzvc : cur.nzvc;
            n.regwrite = bus.id_regwrite;   n.memwrite = bus.id_memwrite;
            n.aluop = bus.id_aluop;         n.alusrc = bus.id_alusrc;
            n.memtoreg = bus.id_memtoreg;   n.flagwrite = bus.id_flagwrite;
            n.instr = bus.id_instr;         n.imm12 = bus.id_imm12;
            n.daddr9 = bus.id_daddr9;       n.lsr = bus.id_lsr;
            n.rd = bus.id_rd;               n.da = bus.id_da;
            n.db = bus.id_db;               n.m_alures = bus.exm_alures;
            n.m_db = bus.exm_db;            n.m_daddr9 = bus.exm_daddr9;
            n.m_memwrite = bus.exm_memwrite; n.m_memtoreg = bus.exm_memtoreg;
            n.m_flagwrite = bus.exm_flagwrite; n.m_regwrite = bus.exm_regwrite;
            n.m_rd = bus.exm_rd;
        end
        return n;
    endfunction

    task automatic compare_all(input string ph, input exp_t o, input exp_t e);
        check({ph, ".nzvc"},          64'(o.nzvc),          64'(e.nzvc));
        check({ph, ".ex_regwrite"},   64'(o.regwrite),      64'(e.regwrite));
        check({ph, ".ex_memwrite"},   64'(o.memwrite),      64'(e.memwrite));
        check({ph, ".ex_aluop"},      64'(o.aluop),         64'(e.aluop));
        check({ph, ".ex_alusrc"},     64'(o.alusrc),        64'(e.alusrc));
        check({ph, ".ex_memtoreg"},   64'(o.memtoreg),      64'(e.memtoreg));
        check({ph, ".ex_flagwrite"},  64'(o.flagwrite),     64'(e.flagwrite));
        check({ph, ".ex_instr"},      64'(o.instr),         64'(e.instr));
        check({ph, ".ex_imm12"},      o.imm12,              e.imm12);
        check({ph, ".ex_daddr9"},     o.daddr9,             e.daddr9);
        check({ph, ".ex_lsr"},        o.lsr,                e.lsr);
        check({ph, ".ex_rd"},         64'(o.rd),            64'(e.rd));
        check({ph, ".ex_da"},         o.da,                 e.da);
        check({ph, ".ex_db"},         o.db,                 e.db);
        check({ph, ".mem_alures"},    o.m_alures,           e.m_alures);
        check({ph, ".mem_db"},        o.m_db,               e.m_db);
        check({ph, ".mem_daddr9"},    o.m_daddr9,           e.m_daddr9);
        check({ph, ".mem_memwrite"},  64'(o.m_memwrite),    64'(e.m_memwrite));
        check({ph, ".mem_memtoreg"},  64'(o.m_memtoreg),    64'(e.m_memtoreg));
        check({ph, ".mem_flagwrite"}, 64'(o.m_flagwrite),   64'(e.m_flagwrite));
        check({ph, ".mem_regwrite"},  64'(o.m_regwrite),    64'(e.m_regwrite));
        check({ph, ".mem_rd"},        64'(o.m_rd),          64'(e.m_rd));
    endtask

    task automatic set_all(input logic v);
        bus.flag_we = v;          bus.alu_nzvc = {4{v}};
        bus.id_regwrite = v;      bus.id_memwrite = v;
        bus.id_aluop = {3{v}};    bus.id_alusrc = {2{v}};
        bus.id_memtoreg = v;      bus.id_flagwrite = v;
        bus.id_instr = {32{v}};   bus.id_imm12 = {64{v}};
        bus.id_daddr9 = {64{v}};  bus.id_lsr = {64{v}};
        bus.id_rd = {5{v}};       bus.id_da = {64{v}};
        bus.id_db = {64{v}};      bus.exm_alures = {64{v}};
        bus.exm_db = {64{v}};     bus.exm_daddr9 = {64{v}};
        bus.exm_memwrite = v;     bus.exm_memtoreg = v;
        bus.exm_flagwrite = v;    bus.exm_regwrite = v;
        bus.exm_rd = {5{v}};
    endtask

    task automatic set_rand();
        bus.flag_we = 1'($urandom);       bus.alu_nzvc = 4'($urandom);
        bus.id_regwrite = 1'($urandom);   bus.id_memwrite = 1'($urandom);
        bus.id_aluop = 3'($urandom);      bus.id_alusrc = src_tbl[$urandom_range(0, 3)];
        bus.id_memtoreg = 1'($urandom);   bus.id_flagwrite = 1'($urandom);
        bus.id_instr = $urandom;          bus.id_imm12 = {52'd0, 12'($urandom)};
        bus.id_daddr9 = {{$urandom}, {$urandom}}; bus.id_lsr = {{$urandom}, {$urandom}};
        bus.id_rd = 5'($urandom);         bus.id_da = {{$urandom}, {$urandom}};
        bus.id_db = {{$urandom}, {$urandom}}; bus.exm_alures = {{$urandom}, {$urandom}};
        bus.exm_db = {{$urandom}, {$urandom}}; bus.exm_daddr9 = {{$urandom}, {$urandom}};
        bus.exm_memwrite = 1'($urandom);  bus.exm_memtoreg = 1'($urandom);
        bus.exm_flagwrite = 1'($urandom); bus.exm_regwrite = 1'($urandom);
        bus.exm_rd = 5'($urandom);
    endtask

    // Called at a falling edge with inputs already driven
    task automatic step(input string ph);
        exp_t e;
        #1;
        if (model_valid) compare_all({ph, ".hold"}, sample(), model_q);
        e = predict(model_q, reset);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        check({ph, ".sb_depth"}, 64'(sb_q.size()), 64'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            compare_all({ph, ".post"}, sample(), e);
            model_q = e;
            model_valid = 1'b1;
        end
        @(negedge clk);
    endtask

    initial begin
        chk_cnt = 0;
        err_cnt = 0;
        model_valid = 1'b0;
        model_q = '0;
        src_tbl = '{ALUSRC_DB, ALUSRC_DADDR9, ALUSRC_IMM12, ALUSRC_LSR};
        reset = 1'b1;
        set_all(1'b1);
        @(negedge clk);

        // Reset with every input at all-ones
        step("reset_ones");

        // Single directed transfer through ID/EX
        reset = 1'b0;
        set_all(1'b0);
        bus.id_da = 64'h0123_4567_89AB_CDEF;
        bus.id_rd = 5'd7;
        bus.id_aluop = 3'b010;
        bus.id_alusrc = ALUSRC_IMM12;
        step("id_ex");
        check("id_ex.da_const", bus.ex_da, 64'h0123_4567_89AB_CDEF);
        check("id_ex.rd_const", 64'(bus.ex_rd), 64'd7);

        // Flag load then hold
        bus.flag_we = 1'b1; bus.alu_nzvc = 4'b0100;
        step("flag_load");
        bus.flag_we = 1'b0; bus.alu_nzvc = 4'b1011;
        step("flag_hold");
        check("flag_hold.nzvc_const", 64'(bus.nzvc), 64'h4);
        check("flag_hold.Z_bit", 64'(bus.nzvc[FLAG_Z]), 64'd1);

        // Reset beats flag_we on the same edge
        bus.flag_we = 1'b1; bus.alu_nzvc = 4'b1111; reset = 1'b1;
        step("flag_reset");
        check("flag_reset.nzvc_const", 64'(bus.nzvc), 64'h0);
        reset = 1'b0; bus.flag_we = 1'b0;

        // Back-to-back EX/MEM stream
        for (int i = 1; i <= 3; i++) begin
            bus.exm_alures = 64'(i * 10);
            step($sformatf("b2b%0d", i));
            check($sformatf("b2b%0d.alures_const", i), bus.mem_alures, 64'(i * 10));
        end

        // Fill with random traffic, then reset mid-stream
        for (int i = 0; i < 10; i++) begin
            set_rand();
            step($sformatf("fill%0d", i));
        end
        set_rand();
        bus.id_da = 64'hDEAD_BEEF_0000_0001;
        bus.exm_alures = 64'hFFFF_0000_FFFF_0000;
        reset = 1'b1;
        step("mid_reset");
        reset = 1'b0;
        set_rand();
        bus.id_da = 64'h0000_0000_0000_0042;
        step("resume");
        check("resume.da_const", bus.ex_da, 64'h42);

        // Random traffic with occasional resets
        for (int i = 0; i < 40; i++) begin
            set_rand();
            reset = ($urandom_range(0, 7) == 0);
            step($sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
